// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, defaults and FSM state type for the multiplier operand dispatcher
package mul_pkg;
  localparam int DATA_W = 8;
  localparam int PROD_W = 2 * DATA_W;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} disp_state_t;
endpackage

// File: rtl/mul_op_fifo.sv
// mul_op_fifo: synchronous operand-pair FIFO, power-of-2 depth, async active-low reset
module mul_op_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  assign level = wp_q - rp_q;
  assign full = level[AW];
  assign empty = level == '0;
  assign rdata = mem_q[rp_q[AW-1:0]];
  always_comb begin
    wp_d = wp_q + {{AW{1'b0}}, push};
    rp_d = rp_q + {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q[AW-1:0]] <= wdata;
endmodule

// File: rtl/mul_operand_dispatcher.sv
// mul_operand_dispatcher: FIFO-buffered job issuer for the start/done multiplier; MUL_TIMEOUT_EN adds a WAIT abort
module mul_operand_dispatcher #(
  parameter int DATA_W = mul_pkg::DATA_W,
  parameter int DEPTH = mul_pkg::DEPTH
`ifdef MUL_TIMEOUT_EN
  , parameter int TIMEOUT = mul_pkg::TIMEOUT
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  output logic                   mul_start,
  output logic [DATA_W-1:0]      mul_a,
  output logic [DATA_W-1:0]      mul_b,
  input  logic                   mul_done,
  input  logic [2*DATA_W-1:0]    mul_product,
  output logic                   out_valid,
  output logic [2*DATA_W-1:0]    out_product,
  output logic [DATA_W-1:0]      out_a,
  output logic [DATA_W-1:0]      out_b,
  output logic [15:0]            issued_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic                   timeout_err
);
  import mul_pkg::*;
  disp_state_t state_q, state_d;
  logic done_q, done_edge, push, pop, full, empty, time_up;
  logic [2*DATA_W-1:0] head;
  logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, out_a_q, out_a_d, out_b_q, out_b_d;
  logic [2*DATA_W-1:0] out_product_q, out_product_d;
  logic [15:0] issued_cnt_q, issued_cnt_d;
  logic mul_start_q, mul_start_d, out_valid_q, out_valid_d, timeout_err_q, timeout_err_d;
  // in_ready is gated by reset so every output reads 0 while rst_n is low
  assign in_ready = rst_n && !full;
  assign push = in_valid && in_ready;
  assign done_edge = mul_done && !done_q;
  assign busy = state_q != IDLE || !empty;
  mul_op_fifo #(.W(2 * DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wdata({in_a, in_b}),
    .rdata(head), .full(full), .empty(empty), .level(fifo_level)
  );
`ifdef MUL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  assign time_up = state_q == WAIT && !done_edge && wait_cnt_q == TW'(TIMEOUT - 1);
  always_comb wait_cnt_d = state_q == WAIT ? wait_cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt_q <= '0;
    else wait_cnt_q <= wait_cnt_d;
`else
  assign time_up = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    mul_start_d = 1'b0;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    out_valid_d = 1'b0;
    out_product_d = out_product_q;
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    issued_cnt_d = issued_cnt_q;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        {mul_a_d, mul_b_d} = head;
        mul_start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (done_edge) begin
        out_product_d = mul_product;
        out_a_d = mul_a_q;
        out_b_d = mul_b_q;
        out_valid_d = 1'b1;
        issued_cnt_d = issued_cnt_q + 1'b1;
        state_d = IDLE;
      end else if (time_up) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    timeout_err_d = timeout_err_q || time_up;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      out_valid_q <= 1'b0;
      out_product_q <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      issued_cnt_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= mul_done;
      mul_start_q <= mul_start_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      out_valid_q <= out_valid_d;
      out_product_q <= out_product_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      issued_cnt_q <= issued_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  assign mul_start = mul_start_q;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_product = out_product_q;
  assign out_a = out_a_q;
  assign out_b = out_b_q;
  assign issued_cnt = issued_cnt_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_mul_operand_dispatcher.sv
// tb_mul_operand_dispatcher: directed vectors with a multiplier stall/leftover-done model and an in-order result scoreboard
module tb_mul_operand_dispatcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic in_ready, mul_start, mul_done, out_valid, busy, timeout_err;
  logic [7:0] mul_a, mul_b, out_a, out_b;
  logic [15:0] mul_product, out_product, issued_cnt;
  logic [2:0] fifo_level;
  int vec = 0, miss = 0;
  bit stall = 0, sticky = 0;
  int lat = 3;
  always #5 clk = ~clk;
  mul_operand_dispatcher #(.DATA_W(8), .DEPTH(4)
`ifdef MUL_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_product(mul_product),
    .out_valid(out_valid), .out_product(out_product), .out_a(out_a), .out_b(out_b),
    .issued_cnt(issued_cnt), .fifo_level(fifo_level), .busy(busy), .timeout_err(timeout_err)
  );
  // multiplier model: drops a leftover done shortly after start, can stall or leave done high
  int mcnt;
  bit mrun;
  logic [7:0] ma, mb;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mul_done <= 1'b0;
      mul_product <= '0;
      mrun <= 0;
      mcnt <= 0;
    end else if (mul_start) begin
      mrun <= 1;
      mcnt <= 0;
      ma <= mul_a;
      mb <= mul_b;
    end else if (mrun) begin
      mcnt <= mcnt + 1;
      if (mcnt == 1) begin
        mul_done <= 1'b0;
        mul_product <= 16'hdead;
      end
      if (mcnt >= lat && !stall) begin
        mul_done <= 1'b1;
        mul_product <= ma * mb;
        mrun <= 0;
      end
    end else if (!sticky) mul_done <= 1'b0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // scoreboard: jobs start in push order, one at a time, each result is the product of its own operands
  logic [15:0] iq[$];
  logic [15:0] got[$];
  bit outst, terr_prev;
  logic [7:0] ca, cb;
  int exp_cnt;
  always @(negedge clk)
    if (!rst_n) begin
      iq.delete();
      outst = 0;
      exp_cnt = 0;
      terr_prev = 0;
    end else begin
      if (mul_start) begin
        if (iq.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL start_unexpected: mul_start with no queued pair");
        end else begin
          chk("start_a", mul_a, iq[0][15:8]);
          chk("start_b", mul_b, iq[0][7:0]);
          ca = iq[0][15:8];
          cb = iq[0][7:0];
          void'(iq.pop_front());
        end
        chk("start_while_busy", outst, 0);
        outst = 1;
      end
      if (out_valid) begin
        chk("valid_outstanding", outst, 1);
        chk("out_product", out_product, ca * cb);
        chk("out_a", out_a, ca);
        chk("out_b", out_b, cb);
        exp_cnt++;
        chk("issued_cnt", issued_cnt, exp_cnt % 65536);
        outst = 0;
        got.push_back(out_product);
      end
      if (timeout_err && !terr_prev) outst = 0;
      terr_prev = timeout_err;
      chk("ready_vs_level", in_ready, fifo_level != 3'd4);
      if (in_valid && in_ready) iq.push_back({in_a, in_b});
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      vec++;
      miss++;
      $display("FAIL push_stuck: in_ready 0 for 200 cycles, required 1");
    end
    tick();
    in_valid = 1'b0;
  endtask
  task automatic wait_out(string name);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      vec++;
      miss++;
      $display("FAIL %s: out_valid 0 for 100 cycles, required 1", name);
    end
  endtask
  task automatic wait_idle(string name);
    int n = 0;
    tick();
    while (busy && n < 500) begin
      tick();
      n++;
    end
    chk(name, busy, 0);
    tick();
    tick();
  endtask
  task automatic check_zero(string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_product"}, out_product, 0);
    chk({tag, "_out_a"}, out_a, 0);
    chk({tag, "_out_b"}, out_b, 0);
    chk({tag, "_issued_cnt"}, issued_cnt, 0);
    chk({tag, "_fifo_level"}, fifo_level, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask
  logic [15:0] t3_exp [6] = '{16'd0, 16'd255, 16'd0, 16'd255, 16'd0, 16'd65025};
  logic [7:0] t3_a [6] = '{8'd0, 8'd255, 8'd255, 8'd1, 8'd0, 8'd255};
  logic [7:0] t3_b [6] = '{8'd255, 8'd1, 8'd0, 8'd255, 8'd0, 8'd255};
  initial begin
    repeat (3) tick();
    @(negedge clk);
    check_zero("rst");
    tick();
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("no_start_after_reset", mul_start, 0);
    end
    // T1: single job latency and result
    tick();
    in_valid = 1'b1;
    in_a = 8'd26;
    in_b = 8'd11;
    @(negedge clk);
    chk("t1_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_start_early", mul_start, 0);
    chk("t1_level", fifo_level, 1);
    @(negedge clk);
    chk("t1_start", mul_start, 1);
    chk("t1_mul_a", mul_a, 26);
    chk("t1_mul_b", mul_b, 11);
    chk("t1_level_popped", fifo_level, 0);
    @(negedge clk);
    chk("t1_start_one_cycle", mul_start, 0);
    wait_out("t1_out");
    chk("t1_product", out_product, 286);
    chk("t1_issued", issued_cnt, 1);
    @(negedge clk);
    chk("t1_valid_one_cycle", out_valid, 0);
    // T2: stalled multiplier fills the FIFO
    tick();
    stall = 1;
    for (int i = 0; i < 5; i++) push(8'(2 * i + 1), 8'(2 * i + 2));
    @(negedge clk);
    chk("t2_level_full", fifo_level, 4);
    chk("t2_ready_full", in_ready, 0);
    chk("t2_busy", busy, 1);
    tick();
    in_valid = 1'b1;
    in_a = 8'd11;
    in_b = 8'd12;
    repeat (3) tick();
    @(negedge clk);
    chk("t2_sixth_held", in_ready, 0);
    chk("t2_level_held", fifo_level, 4);
    tick();
    stall = 0;
    push(8'd11, 8'd12);
    wait_idle("t2_drain");
    chk("t2_issued", issued_cnt, 7);
    chk("t2_no_timeout", timeout_err, 0);
    // T3: operand extremes, results in order
    got.delete();
    for (int i = 0; i < 6; i++) push(t3_a[i], t3_b[i]);
    wait_idle("t3_drain");
    chk("t3_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("t3_product%0d", i), got[i], t3_exp[i]);
    chk("t3_issued", issued_cnt, 13);
    // T4: done level left high between jobs
    sticky = 1;
    got.delete();
    push(8'd2, 8'd3);
    push(8'd4, 8'd5);
    wait_idle("t4_drain");
    chk("t4_done_left_high", mul_done, 1);
    chk("t4_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t4_product0", got[0], 6);
      chk("t4_product1", got[1], 20);
    end
    repeat (3) tick();
    chk("t4_no_extra", got.size(), 2);
    chk("t4_issued", issued_cnt, 15);
    sticky = 0;
    repeat (2) tick();
    // T5: reset during WAIT with pairs queued
    stall = 1;
    push(8'd20, 8'd1);
    push(8'd21, 8'd2);
    push(8'd22, 8'd3);
    push(8'd23, 8'd4);
    repeat (2) tick();
    @(negedge clk);
    chk("t5_level_before", fifo_level, 3);
    chk("t5_busy_before", busy, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_zero("t5_async");
    stall = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_level_after", fifo_level, 0);
      chk("t5_no_start", mul_start, 0);
      chk("t5_idle", busy, 0);
    end
`ifdef MUL_TIMEOUT_EN
    // T6: multiplier never answers, job aborted after TIMEOUT cycles of WAIT
    begin
      int n = 0;
      stall = 1;
      push(8'd7, 8'd7);
      push(8'd8, 8'd9);
      @(negedge clk);
      while (!mul_start && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("t6_first_start", mul_start, 1);
      repeat (15) @(negedge clk);
      chk("t6_err_not_yet", timeout_err, 0);
      repeat (2) @(negedge clk);
      chk("t6_err_set", timeout_err, 1);
      chk("t6_issued_unchanged", issued_cnt, 0);
      stall = 0;
      wait_out("t6_out");
      chk("t6_next_product", out_product, 72);
      chk("t6_issued", issued_cnt, 1);
      chk("t6_err_sticky", timeout_err, 1);
      wait_idle("t6_drain");
    end
`else
    chk("no_timeout_logic", timeout_err, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
